// File: rtl/uart_pkg.sv
// Shared FSM state type and sampling constants for the oversampled UART.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF = 100000000;
  localparam int unsigned BAUD_DEF     = 9600;
  localparam int unsigned OS           = 16;
  localparam int unsigned SAMPLE_LO    = 7;
  localparam int unsigned SAMPLE_MID   = 8;
  localparam int unsigned SAMPLE_HI    = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase reset by clr.
module baud_tick_gen #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampled 8N1 UART receiver with majority voting, start-glitch
// rejection and framing-error reporting.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned BAUD     = BAUD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV     = CLK_FREQ / (BAUD * OS);
  localparam logic [3:0]  OS_LAST = 4'(OS - 1);
  localparam logic [3:0]  S_LO    = 4'(SAMPLE_LO);
  localparam logic [3:0]  S_MID   = 4'(SAMPLE_MID);
  localparam logic [3:0]  S_HI    = 4'(SAMPLE_HI);

  logic       sync1, sync2, sync3;
  logic       din_s, fall, maj;
  logic       tick, tick_clr;
  rx_state_t  state, state_n;
  logic [3:0] os_cnt, os_cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift_reg, shift_n, data_n;
  logic       s_lo, s_lo_n, s_mid, s_mid_n;
  logic       valid_n, frame_err_n, busy_n;

  // Two-flop synchroniser plus a third copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign din_s = sync2;
  assign fall  = sync3 & ~sync2;
  assign maj   = (s_lo & s_mid) | (s_lo & din_s) | (s_mid & din_s);

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      s_lo      <= 1'b0;
      s_mid     <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      os_cnt    <= os_cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      s_lo      <= s_lo_n;
      s_mid     <= s_mid_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    os_cnt_n    = os_cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift_reg;
    s_lo_n      = s_lo;
    s_mid_n     = s_mid;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    busy_n      = 1'b0;
    tick_clr    = 1'b0;

    // In-frame bit timing: os_cnt wraps 15 -> 0 at each bit boundary
    if (tick && ((state == START) || (state == DATA) || (state == STOP))) begin
      os_cnt_n = os_cnt + 4'd1;
      if (os_cnt == S_LO)  s_lo_n  = din_s;
      if (os_cnt == S_MID) s_mid_n = din_s;
    end

    unique case (state)
      IDLE: begin
        if (fall) begin
          state_n  = START;
          os_cnt_n = '0;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if ((os_cnt == S_HI) && maj) begin
            state_n = IDLE;
          end else if (os_cnt == OS_LAST) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt == S_HI) shift_n[bit_idx] = maj;
          if (os_cnt == OS_LAST) begin
            if (bit_idx == 3'd7) state_n = STOP;
            else                 bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // Decide mid-stop-bit and leave early to tolerate baud mismatch
        if (tick && (os_cnt == S_HI)) begin
          if (maj) begin
            data_n  = shift_reg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_IDLE;
            os_cnt_n    = '0;
          end
        end
      end
      WAIT_IDLE: begin
        // Need a full bit time of continuous high before re-arming
        if (!din_s) begin
          os_cnt_n = '0;
        end else if (tick) begin
          if (os_cnt == OS_LAST) state_n = IDLE;
          else                   os_cnt_n = os_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed scoreboard bench for uart_rx_os at a reduced clock (DIV = 10).
module tb_uart_rx_os;

  localparam int unsigned CLK_FREQ = 1536000;
  localparam int unsigned BAUD     = 9600;
  localparam int          DIV      = 10;
  localparam int          BITC     = DIV * 16;
  localparam int          GL_LO    = 9 * DIV - 4;
  localparam int          GL_HI    = 9 * DIV + 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       valid;
  logic [7:0] data;
  logic       frame_err;
  logic       busy;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         n_valid  = 0;
  int         n_ferr   = 0;
  int         cyc      = 0;
  logic       busy_seen = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic       prev_busy  = 1'b0;
  logic [7:0] exp_q[$];
  int         vcyc[$];

  uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .valid     (valid),
    .data      (data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid strobe
  always @(negedge clk) begin
    if (busy === 1'b1) busy_seen = 1'b1;
    if (valid === 1'b1) begin
      n_valid++;
      vcyc.push_back(cyc);
      check("valid_single_cycle", 32'(prev_valid), 32'd0);
      check("valid_without_ferr", 32'(frame_err), 32'd0);
      check("busy_falls_with_valid", {30'd0, prev_busy, busy}, 32'd2);
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_data", 32'(data), 32'(exp_q.pop_front()));
    end
    if (frame_err === 1'b1) begin
      n_ferr++;
      check("ferr_single_cycle", 32'(prev_ferr), 32'd0);
    end
    prev_valid = valid;
    prev_ferr  = frame_err;
    prev_busy  = busy;
  end

  task automatic hold(input int n, input logic lvl);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din = lvl;
    end
  endtask

  // Drive one 8N1 frame; glitch inverts a one-tick window around the os_cnt=8 sample
  task automatic send_frame(input logic [7:0] b, input int bit_cyc, input logic stop,
                            input bit glitch, input int abort_at);
    logic [9:0] fr;
    bit         g;
    fr = {stop, b, 1'b0};
    for (int c = 0; c < 10 * bit_cyc; c++) begin
      if ((abort_at != 0) && (c == abort_at)) return;
      g = glitch && ((c % BITC) >= GL_LO) && ((c % BITC) < GL_HI);
      @(negedge clk);
      din = fr[4'(c / bit_cyc)] ^ g;
    end
  endtask

  initial begin
    int v0, f0;
    rst = 1'b0;
    din = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    hold(BITC, 1'b1);

    // Ideal 0x55
    v0 = n_valid; f0 = n_ferr;
    exp_q.push_back(8'h55);
    send_frame(8'h55, BITC, 1'b1, 1'b0, 0);
    hold(2 * BITC, 1'b1);
    check("b55_valid_count", 32'(n_valid - v0), 32'd1);
    check("b55_ferr_count", 32'(n_ferr - f0), 32'd0);
    check("b55_data_held", 32'(data), 32'h55);

    // Back-to-back 0xA3, 0x0F
    v0 = n_valid;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_frame(8'hA3, BITC, 1'b1, 1'b0, 0);
    send_frame(8'h0F, BITC, 1'b1, 1'b0, 0);
    hold(2 * BITC, 1'b1);
    check("b2b_valid_count", 32'(n_valid - v0), 32'd2);
    check("b2b_interval", 32'(vcyc[vcyc.size() - 1] - vcyc[vcyc.size() - 2]), 32'(10 * BITC));
    check("b2b_data_held", 32'(data), 32'h0F);

    // 3-tick start glitch
    v0 = n_valid; f0 = n_ferr;
    busy_seen = 1'b0;
    hold(3 * DIV, 1'b0);
    hold(2 * BITC, 1'b1);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    check("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);
    check("glitch_data_kept", 32'(data), 32'h0F);

    // 0x41 with bad stop bit, line held low, then a short high and a false start
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h41, BITC, 1'b0, 1'b0, 0);
    hold(BITC, 1'b0);
    check("ferr_busy_while_low", 32'(busy), 32'd1);
    hold(BITC, 1'b0);
    hold(12 * DIV, 1'b1);
    hold(BITC, 1'b0);
    hold(12 * BITC, 1'b1);
    check("ferr_count", 32'(n_ferr - f0), 32'd1);
    check("ferr_no_valid", 32'(n_valid - v0), 32'd0);
    check("ferr_data_kept", 32'(data), 32'h0F);
    check("ferr_recovered_idle", 32'(busy), 32'd0);

    v0 = n_valid;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, BITC, 1'b1, 1'b0, 0);
    hold(2 * BITC, 1'b1);
    check("b5a_valid_count", 32'(n_valid - v0), 32'd1);
    check("b5a_data_held", 32'(data), 32'h5A);

    // 0xC6 at +2% baud with mid-sample corruption on every bit
    v0 = n_valid; f0 = n_ferr;
    exp_q.push_back(8'hC6);
    send_frame(8'hC6, BITC * 100 / 102, 1'b1, 1'b1, 0);
    hold(2 * BITC, 1'b1);
    check("bc6_valid_count", 32'(n_valid - v0), 32'd1);
    check("bc6_no_ferr", 32'(n_ferr - f0), 32'd0);
    check("bc6_data_held", 32'(data), 32'hC6);

    // Reset during bit 4 of 0x3C
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, BITC, 1'b1, 1'b0, 5 * BITC + BITC / 2);
    @(negedge clk);
    rst = 1'b0;
    din = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    hold(12 * BITC, 1'b1);
    check("midrst_no_valid", 32'(n_valid - v0), 32'd0);
    check("midrst_no_ferr", 32'(n_ferr - f0), 32'd0);
    check("midrst_data_cleared", 32'(data), 32'd0);

    v0 = n_valid;
    exp_q.push_back(8'h81);
    send_frame(8'h81, BITC, 1'b1, 1'b0, 0);
    hold(2 * BITC, 1'b1);
    check("b81_valid_count", 32'(n_valid - v0), 32'd1);
    check("b81_data_held", 32'(data), 32'h81);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver (8N1, LSB first) that converts the serial `din` line into byte-wide `data` plus a one-cycle `valid` strobe.
- Sits directly upstream of the string-matcher, the display-flow and the receive-counter logic; those consumers use `valid`/`data` exactly as they do today.
- Adds 16x oversampling, 3-sample majority voting, start-bit glitch rejection and framing-error reporting.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OS, 16, oversampling ratio (ticks per bit); fixed at 16.
- DIV, CLK_FREQ/(BAUD*OS) = 651 (integer truncation), clock cycles per oversample tick; derived localparam.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  1  asynchronous serial input; idles high.
- valid  out  1  one-cycle pulse: a good byte is on `data`.
- data  out  8  last correctly framed byte; held between pulses.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asynchronous and active-low on `rst`; all state is cleared when it asserts.
- Reset values: valid=0, data=8'h00, frame_err=0, busy=0, FSM=IDLE, synchroniser flops=1, counters=0.
- Synchroniser: `din` passes through two flops before any use. The start-edge detector uses a third delayed copy.
- Tick generator: counts 0..DIV-1 and pulses `tick` for one cycle at DIV-1.
  - Cleared to 0 on the start edge detected in IDLE, so the bit phase is aligned to the falling edge.
- Bit timing: `os_cnt` runs 0..15 per bit and advances on `tick`.
  - Samples are taken at os_cnt 7, 8 and 9.
  - The bit value is the majority (2 of 3), decided on the tick at os_cnt 9.
  - The bit ends at the tick with os_cnt 15.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a synchronised 1->0 transition moves to START and clears os_cnt and the tick counter.
  - START: at the os_cnt-9 decision, majority 1 -> IDLE (glitch rejected, no output). Majority 0 -> continue to os_cnt 15, then DATA with bit_idx=0.
  - DATA: the bit decided at os_cnt 9 is shifted into shift_reg[bit_idx] (LSB first). At os_cnt 15: bit_idx==7 -> STOP, otherwise bit_idx+1.
  - STOP: at the os_cnt-9 decision:
    - majority 1 -> data<=shift_reg, valid=1 for the next clk cycle, then IDLE immediately; the second half of the stop bit is not waited for, which tolerates baud mismatch.
    - majority 0 -> frame_err=1 for one cycle, `data` unchanged, then WAIT_IDLE.
  - WAIT_IDLE: stays until the synchronised line is 1 for one full bit time (16 ticks), then IDLE. This covers break conditions and a line held low, and stops false restarts.
- Latency: `valid` rises 2 (synchroniser) + 1 clk after the tick at os_cnt 9 of the stop bit, about 9.5 bit times after the start edge.
- `valid` and `frame_err` are never high in the same cycle and never stay high for more than 1 cycle.
- Back-to-back frames: a start edge arriving while in STOP (after the decision) or in IDLE is accepted with no lost byte.
- Reset mid-frame: any partial byte is discarded and no strobe is produced. The next byte is received only after a fresh falling edge with rst high.
- Width rules: tick counter is $clog2(DIV) bits; os_cnt is 4 bits; bit_idx is 3 bits. All counters wrap only where stated above.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Constants: CLK_FREQ_DEF=100000000, BAUD_DEF=9600, OS=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
- One natural sub-module: `baud_tick_gen`. Parameter DIV; inputs clk, rst, clr; output tick. A later oversampled transmitter can reuse it.

Test Plan:
- 0x55 sent at 9600 baud, ideal timing -> exactly one `valid` pulse, data=8'h55, frame_err never high, busy falls in the same cycle valid rises.
- 0xA3 then 0x0F back-to-back (no idle gap between stop and next start) -> two valid pulses about 1.04 ms apart, data 8'hA3 then 8'h0F.
- `din` low pulse of 3 ticks (3*651 cycles) from idle -> busy pulses high, then returns to IDLE; no valid, no frame_err; data keeps its previous value.
- 0x41 sent with stop bit forced 0, line then held low 2 bit times -> frame_err pulse once, no valid, data unchanged (8'h0F). A following 0x5A is received only after the line has been high 16 ticks, and gives data=8'h5A.
- 0xC6 with a 1-cycle-per-tick inversion on the os_cnt=8 sample of every bit, plus transmitter baud +2% (9792) -> majority vote recovers data=8'hC6, valid once.
- rst driven low during bit 4 of 0x3C, released, then 0x81 sent -> no output for 0x3C, all outputs 0 during reset, data=8'h81 with a single valid pulse.
